branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Sits in the fetch stage, upstream of the hazard unit.
- Each cycle it predicts next-PC redirection for the instruction being fetched.
- When a branch resolves in EX/MEM it trains the table. It also raises the misprediction indication and recovery PC that the hazard unit consumes to flush IF/ID and ID/EX.

Parameters:
- IDX_W, 4, index bits; table depth = 2**IDX_W entries.
- CNT_INIT, 2'b01, counter value loaded into every entry at reset (weakly not-taken).

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- pc_if  input  32  PC of instruction currently in fetch
- pred_taken  output  1  predict redirect to pred_target (combinational)
- pred_target  output  32  predicted target; 0 when pred_taken=0
- upd_valid  input  1  resolved BEQ/BNE present in EX/MEM
- upd_en  input  1  EX/MEM advancing this cycle (not stalled); training happens only when high
- upd_pc  input  32  PC of the resolved branch
- upd_taken  input  1  actual outcome
- upd_target  input  32  actual branch target
- upd_pred_taken  input  1  prediction carried down the pipe with the branch
- upd_pred_target  input  32  predicted target carried down the pipe
- mispredict  output  1  resolved branch disagrees with its prediction (combinational)
- recover_pc  output  32  correct next PC when mispredict=1; otherwise upd_pc+4
- br_count  output  16  resolved branches trained since reset
- miss_count  output  16  mispredictions trained since reset

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. Each entry holds: valid, tag, 2-bit cnt, 32-bit target.
- Reset (RST high at a rising edge): all valid=0, all cnt=CNT_INIT, all targets=0, br_count=0, miss_count=0. Reset overrides any same-cycle update. Reset asserted mid-training discards that update.
- Lookup is purely combinational on registered state with zero latency.
  - hit = valid && tag match on pc_if.
  - pred_taken = hit && cnt[1].
  - pred_target = entry target when pred_taken=1, else 0.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Training fires when upd_valid && upd_en, at the rising edge. Upd lookup uses the upd_pc index and tag.
  - Hit, taken: cnt = min(cnt+1, 3); target = upd_target.
  - Hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag=upd tag, cnt=2'b10, target=upd_target. Any previous occupant is evicted.
  - Miss, not taken: no change to the table.
- mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
  - mispredict is independent of upd_en. The hazard unit qualifies it.
- recover_pc = upd_target when upd_taken=1, else upd_pc+4 (mod 2^32).
- Counters:
  - br_count increments once per training event.
  - miss_count increments on a training event with mispredict=1.
  - Both saturate at 16'hFFFF.
- Simultaneous lookup and training on the same index: lookup returns pre-update contents. No write-through bypass. The new value is visible the next cycle.
- upd_en low while upd_valid is high: no table or counter change. The same branch retrains when upd_en rises; exactly one training per advancing branch.
- upd_pc[1:0] and pc_if[1:0] are ignored.

Test Plan:
- Reset, then pc_if=0x0000_0040 -> pred_taken=0, pred_target=0, br_count=0, miss_count=0.
- Train pc=0x40 taken to target 0x80, upd_pred_taken=0, upd_en=1. Expect mispredict=1 and recover_pc=0x80 that cycle. Next cycle, pc_if=0x40 gives pred_taken=1, pred_target=0x80, miss_count=1.
- Same branch taken twice more -> cnt reaches 3. Four not-taken trainings then give pred_taken=0 after the 2nd; cnt saturates at 0 after the 4th. Each not-taken with upd_pred_taken=0 gives mispredict=0, recover_pc=0x44.
- Alias: train pc=0x40 taken, then pc=0x440 taken to 0x900 (same index, IDX_W=4). Expect lookup of 0x40 -> pred_taken=0 and lookup of 0x440 -> pred_target=0x900.
- Stall: upd_valid=1, upd_en=0 for 3 cycles, then 1 for 1 cycle -> br_count increments by exactly 1; table changes only after the enabled edge.
- Same-cycle lookup and update of pc=0x40 -> old prediction that cycle, new next cycle. RST asserted together with upd_en=1 -> table cleared, counters 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX/MEM training/recovery signals of the branch predictor.
// master drives PC and resolved-branch info; slave (the predictor) returns predictions.
interface branch_predictor_if;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] recover_pc;
    logic [15:0] br_count;
    logic [15:0] miss_count;

    modport master (
        output pc_if, upd_valid, upd_en, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, recover_pc, br_count, miss_count
    );

    modport slave (
        input  pc_if, upd_valid, upd_en, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, recover_pc, br_count, miss_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters; zero-latency lookup,
// training on resolved branches, misprediction/recovery signalling and statistics.
module branch_predictor #(
    parameter int unsigned IDX_W    = 4,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic                CLK,
    input  logic                RST,
    branch_predictor_if.slave   bp
);
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [1:0]       cnt_q [DEPTH];
    logic [31:0]      tgt_q [DEPTH];
    logic [15:0]      br_q;
    logic [15:0]      miss_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             train;
    logic             mispredict;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^bp.pc_if[1:0];

    always_comb begin
        lk_idx = bp.pc_if[IDX_W+1:2];
        lk_tag = bp.pc_if[31:IDX_W+2];
        lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        bp.pred_taken  = lk_hit && cnt_q[lk_idx][1];
        bp.pred_target = (lk_hit && cnt_q[lk_idx][1]) ? tgt_q[lk_idx] : '0;
    end

    always_comb begin
        up_idx = bp.upd_pc[IDX_W+1:2];
        up_tag = bp.upd_pc[31:IDX_W+2];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        train  = bp.upd_valid && bp.upd_en;
        // mispredict is left unqualified by upd_en; the hazard unit gates it
        mispredict = bp.upd_valid &&
                     ((bp.upd_pred_taken != bp.upd_taken) ||
                      (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));
        bp.mispredict = mispredict;
        bp.recover_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
        bp.br_count   = br_q;
        bp.miss_count = miss_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= CNT_INIT;
                tgt_q[i] <= '0;
            end
            br_q   <= '0;
            miss_q <= '0;
        end else if (train) begin
            if (up_hit) begin
                if (bp.upd_taken) begin
                    cnt_q[up_idx] <= (cnt_q[up_idx] == 2'b11) ? 2'b11 : cnt_q[up_idx] + 2'd1;
                    tgt_q[up_idx] <= bp.upd_target;
                end else begin
                    cnt_q[up_idx] <= (cnt_q[up_idx] == 2'b00) ? 2'b00 : cnt_q[up_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                cnt_q[up_idx]   <= 2'b10;
                tgt_q[up_idx]   <= bp.upd_target;
            end
            if (br_q != '1)
                br_q <= br_q + 16'd1;
            if (mispredict && (miss_q != '1))
                miss_q <= miss_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench for branch_predictor: directed test-plan sequence followed by
// randomized traffic, checked against a behavioural BTB model.
module tb_branch_predictor;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if bp ();

    branch_predictor #(.IDX_W(IDX_W), .CNT_INIT(2'b01)) dut (
        .CLK (clk),
        .RST (rst),
        .bp  (bp)
    );

    typedef struct {
        string       name;
        bit          pt;
        bit [31:0]   ptgt;
        bit          mp;
        bit [31:0]   rpc;
        bit [15:0]   br;
        bit [15:0]   miss;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model: one slot per index, keyed by the PC bits above the index.
    bit        m_valid [DEPTH];
    bit [31:0] m_key   [DEPTH];
    int        m_cnt   [DEPTH];
    bit [31:0] m_tgt   [DEPTH];
    int        m_br, m_miss;

    function automatic int unsigned slot(input bit [31:0] pc);
        return (pc / 4) % DEPTH;
    endfunction

    function automatic bit [31:0] key(input bit [31:0] pc);
        return pc / (4 * DEPTH);
    endfunction

    function automatic bit m_hit(input bit [31:0] pc);
        return m_valid[slot(pc)] && (m_key[slot(pc)] == key(pc));
    endfunction

    function automatic bit m_pred(input bit [31:0] pc);
        return m_hit(pc) && (m_cnt[slot(pc)] >= 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_key[i] = 0; m_cnt[i] = 1; m_tgt[i] = 0;
        end
        m_br = 0; m_miss = 0;
    endtask

    task automatic m_train(input bit [31:0] pc, input bit taken, input bit [31:0] tgt, input bit mp);
        int unsigned s;
        s = slot(pc);
        if (m_hit(pc)) begin
            if (taken) begin
                m_cnt[s] = (m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1;
                m_tgt[s] = tgt;
            end else begin
                m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
            end
        end else if (taken) begin
            m_valid[s] = 1; m_key[s] = key(pc); m_cnt[s] = 2; m_tgt[s] = tgt;
        end
        if (m_br < 65535) m_br++;
        if (mp && m_miss < 65535) m_miss++;
    endtask

    // Drive one cycle of inputs, enqueue the expected outputs, then advance the model past the edge.
    task automatic step(input string name, input bit do_rst, input bit [31:0] lpc,
                        input bit uv, input bit ue, input bit [31:0] upc, input bit ut,
                        input bit [31:0] utgt, input bit upt, input bit [31:0] uptgt);
        exp_t e;
        @(posedge clk);
        #1;
        rst                = do_rst;
        bp.pc_if           = lpc;
        bp.upd_valid       = uv;
        bp.upd_en          = ue;
        bp.upd_pc          = upc;
        bp.upd_taken       = ut;
        bp.upd_target      = utgt;
        bp.upd_pred_taken  = upt;
        bp.upd_pred_target = uptgt;
        e.name = name;
        e.pt   = m_pred(lpc);
        e.ptgt = e.pt ? m_tgt[slot(lpc)] : 32'h0;
        e.mp   = uv && ((upt != ut) || (ut && uptgt != utgt));
        e.rpc  = ut ? utgt : upc + 32'd4;
        e.br   = 16'(m_br);
        e.miss = 16'(m_miss);
        q.push_back(e);
        if (do_rst) m_reset();
        else if (uv && ue) m_train(upc, ut, utgt, e.mp);
    endtask

    task automatic look(input string name, input bit [31:0] lpc);
        step(name, 0, lpc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cmp(input string name, input string field, input bit [31:0] act, input bit [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "pred_taken",  32'(bp.pred_taken),  32'(e.pt));
            cmp(e.name, "pred_target", bp.pred_target,      e.ptgt);
            cmp(e.name, "mispredict",  32'(bp.mispredict),  32'(e.mp));
            cmp(e.name, "recover_pc",  bp.recover_pc,       e.rpc);
            cmp(e.name, "br_count",    32'(bp.br_count),    32'(e.br));
            cmp(e.name, "miss_count",  32'(bp.miss_count),  32'(e.miss));
        end
    end

    initial begin
        bit [31:0] lpc, upc, utgt, uptgt;
        bit        uv, ue, ut, upt, r;

        bp.pc_if = '0; bp.upd_valid = 0; bp.upd_en = 0; bp.upd_pc = '0;
        bp.upd_taken = 0; bp.upd_target = '0; bp.upd_pred_taken = 0; bp.upd_pred_target = '0;
        m_reset();
        repeat (2) @(posedge clk);

        look("reset_lookup", 32'h40);
        step("train_first", 0, 32'h40, 1, 1, 32'h40, 1, 32'h80, 0, 32'h0);
        look("after_alloc", 32'h40);
        step("taken2", 0, 32'h40, 1, 1, 32'h40, 1, 32'h80, 1, 32'h80);
        step("taken3", 0, 32'h40, 1, 1, 32'h40, 1, 32'h80, 1, 32'h80);
        for (int i = 0; i < 4; i++)
            step($sformatf("nt%0d", i), 0, 32'h40, 1, 1, 32'h40, 0, 32'h0, 0, 32'h0);
        look("after_nt", 32'h40);

        step("alias_a", 0, 32'h40,  1, 1, 32'h40,  1, 32'h80,  0, 32'h0);
        step("alias_b", 0, 32'h40,  1, 1, 32'h440, 1, 32'h900, 0, 32'h0);
        look("alias_lk40",  32'h40);
        look("alias_lk440", 32'h440);

        for (int i = 0; i < 3; i++)
            step($sformatf("stall%0d", i), 0, 32'h84, 1, 0, 32'h84, 1, 32'h200, 0, 32'h0);
        step("stall_go", 0, 32'h84, 1, 1, 32'h84, 1, 32'h200, 0, 32'h0);
        look("stall_after", 32'h84);

        step("same_cycle", 0, 32'h43, 1, 1, 32'h40, 1, 32'h100, 0, 32'h0);
        look("same_next", 32'h40);
        step("rst_with_upd", 1, 32'h40, 1, 1, 32'h40, 1, 32'h300, 0, 32'h0);
        look("post_rst_40", 32'h40);
        look("post_rst_84", 32'h84);

        for (int n = 0; n < 500; n++) begin
            lpc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            upc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            uv    = ($urandom_range(0, 3) != 0);
            ue    = ($urandom_range(0, 3) != 0);
            ut    = $urandom_range(0, 1) != 0;
            utgt  = 32'($urandom_range(0, 7)) << 2;
            if ($urandom_range(0, 1) != 0) begin
                upt   = m_pred(upc);
                uptgt = upt ? m_tgt[slot(upc)] : 32'h0;
            end else begin
                upt   = $urandom_range(0, 1) != 0;
                uptgt = 32'($urandom_range(0, 7)) << 2;
            end
            r = ($urandom_range(0, 63) == 0);
            step("rand", r, lpc, uv, ue, upc, ut, utgt, upt, uptgt);
        end

        @(posedge clk);
        #1;
        rst = 0; bp.upd_valid = 0; bp.upd_en = 0;
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
